// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM state
// encoding, the base value of the source-ID header byte and a width helper.
package uart_tx_arbiter_pkg;

    // Arbiter FSM states; anything other than ST_IDLE means a packet is granted.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_e;

    // Header byte is HEADER_BASE + requester index, i.e. ASCII '0'..'7'.
    localparam logic [7:0] HEADER_BASE = 8'h30;

    // Index width for n requesters, never narrower than one bit.
    function automatic int clog2_w(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage : uart_tx_arbiter_pkg

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: returns the first valid requester found
// searching upward (with wrap) from the one after last_grant_i.
module rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = clog2_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDW-1:0]     last_grant_i,
    output logic [IDW-1:0]     winner_o,
    output logic               any_valid_o
);

    logic           found_s;
    logic [IDW-1:0] idx_s;

    // Rotating priority search starting just above the previous winner.
    always_comb begin
        winner_o    = '0;
        found_s     = 1'b0;
        idx_s       = '0;
        any_valid_o = |valid_i;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = IDW'((int'(last_grant_i) + k) % NUM_REQ);
            if (!found_s && valid_i[idx_s]) begin
                found_s  = 1'b1;
                winner_o = idx_s;
            end else begin
                found_s  = found_s;
                winner_o = winner_o;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/uart_tx_arbiter.sv
// Multiplexes NUM_REQ byte-stream requesters onto one UART transmit FIFO
// write port. A requester is granted for a whole packet (optionally prefixed
// by a source-ID header byte); a packet that stalls for TIMEOUT valid-low
// cycles is abandoned with a one-cycle abort pulse.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int HEADER_EN = 1,
    parameter  int TIMEOUT   = 1023,
    localparam int IDW       = clog2_w(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_strobe,
    input  logic                 tx_full,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 abort
);

    localparam int SW = $clog2(TIMEOUT + 1);

    state_e         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [SW-1:0]  stall_q, stall_d;
    logic           tx_strobe_q, tx_strobe_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           abort_q, abort_d;

    logic [IDW-1:0]     winner_s;
    logic               any_valid_s;
    logic               issue_ok_s;
    logic               sel_valid_s;
    logic               sel_last_s;
    logic [7:0]         sel_data_s;
    logic [NUM_REQ-1:0] req_ready_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_arbiter (
        .valid_i      (req_valid),
        .last_grant_i (last_grant_q),
        .winner_o     (winner_s),
        .any_valid_o  (any_valid_s)
    );

    // A write may only be issued when the FIFO has room and the previous
    // cycle carried no strobe, so tx_full always reflects the last write.
    assign issue_ok_s = !tx_full && !tx_strobe_q;

    // Route the granted requester's valid/last/data to the FSM.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDW'(i)) begin
                sel_valid_s = req_valid[i];
                sel_last_s  = req_last[i];
                sel_data_s  = req_data[8*i +: 8];
            end else begin
                sel_valid_s = sel_valid_s;
                sel_last_s  = sel_last_s;
                sel_data_s  = sel_data_s;
            end
        end
    end

    // Next-state, handshake and output-register logic of the packet FSM.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        stall_d      = stall_q;
        tx_strobe_d  = 1'b0;
        tx_data_d    = tx_data_q;
        abort_d      = 1'b0;
        req_ready_s  = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_valid_s) begin
                    grant_d = winner_s;
                    stall_d = '0;
                    state_d = (HEADER_EN != 0) ? ST_HEADER : ST_PAYLOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_HEADER: begin
                if (issue_ok_s) begin
                    tx_strobe_d = 1'b1;
                    tx_data_d   = HEADER_BASE + 8'(grant_q);
                    stall_d     = '0;
                    state_d     = ST_PAYLOAD;
                end else begin
                    state_d = ST_HEADER;
                end
            end

            ST_PAYLOAD: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready_s[i] = (grant_q == IDW'(i)) ? issue_ok_s : 1'b0;
                end
                if (sel_valid_s && issue_ok_s) begin
                    tx_strobe_d = 1'b1;
                    tx_data_d   = sel_data_s;
                    stall_d     = '0;
                    if (sel_last_s) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else if (!sel_valid_s) begin
                    // Only cycles without data count toward the timeout;
                    // back-pressure from a full FIFO never aborts a packet.
                    if (stall_q >= SW'(TIMEOUT - 1)) begin
                        abort_d      = 1'b1;
                        last_grant_d = grant_q;
                        stall_d      = '0;
                        state_d      = ST_IDLE;
                    end else begin
                        stall_d = stall_q + SW'(1);
                    end
                end else begin
                    stall_d = stall_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; requester 0 wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
            stall_q      <= '0;
            tx_strobe_q  <= 1'b0;
            tx_data_q    <= 8'h00;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            stall_q      <= stall_d;
            tx_strobe_q  <= tx_strobe_d;
            tx_data_q    <= tx_data_d;
            abort_q      <= abort_d;
        end
    end

    assign req_ready = req_ready_s;
    assign tx_data   = tx_data_q;
    assign tx_strobe = tx_strobe_q;
    assign busy      = (state_q != ST_IDLE);
    assign grant_id  = grant_q;
    assign abort     = abort_q;

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scripted and random packet
// sources, a packet-level reference model of the expected byte stream and
// grant order, and protocol monitors on the FIFO write port.
module tb_uart_tx_arbiter;

    localparam int NR   = 4;
    localparam int TMO  = 15;
    localparam int MAXB = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_strobe;
    logic        tx_full;
    logic        busy;
    logic [1:0]  grant_id;
    logic        abort;

    uart_tx_arbiter #(.NUM_REQ(NR), .HEADER_EN(1), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
        .tx_strobe(tx_strobe), .tx_full(tx_full), .busy(busy),
        .grant_id(grant_id), .abort(abort)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Source scripts
    int         src_len   [NR];
    logic [7:0] src_data  [NR][MAXB];
    bit         src_last  [NR][MAXB];
    int         src_ptr   [NR];
    bit         src_drop  [NR];
    bit         inpkt     [NR];
    bit         abandoned [NR];
    int         lowrun    [NR];
    bit         gaps_en;
    int         full_mode;
    int         full_after;

    // Observations and expectations
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    int         gnt_q[$];
    int         exp_g[$];
    int b2b_viol, full_viol, ready_viol, hold_viol;
    int abort_cnt, abort_busy_viol, fire_cyc, abort_cyc;
    bit budget_hit;

    task automatic clear_sources();
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 0; src_ptr[i] = 0; src_drop[i] = 1'b0;
            inpkt[i] = 1'b0; abandoned[i] = 1'b0; lowrun[i] = 0;
        end
        gaps_en = 1'b0; full_mode = 0; full_after = 0;
    endtask

    task automatic add_byte(input int id, input logic [7:0] d, input bit l);
        src_data[id][src_len[id]] = d;
        src_last[id][src_len[id]] = l;
        src_len[id]++;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; tx_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model: packets are granted whole, in rotating order among
    // requesters that still have packets, starting after requester NR-1.
    task automatic build_expected();
        int  mp[NR];
        bit  alive[NR];
        int  last;
        int  pick;
        bit  done;
        exp_q.delete(); exp_g.delete();
        for (int i = 0; i < NR; i++) begin mp[i] = 0; alive[i] = 1'b1; end
        last = NR - 1;
        for (int guard = 0; guard < 64; guard++) begin
            pick = -1;
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (last + k) % NR;
                if (pick < 0 && alive[c] && mp[c] < src_len[c]) pick = c;
            end
            if (pick < 0) break;
            exp_g.push_back(pick);
            exp_q.push_back(8'(8'h30 + pick));
            if (src_drop[pick]) begin
                exp_q.push_back(src_data[pick][mp[pick]]);
                alive[pick] = 1'b0;
            end else begin
                done = 1'b0;
                while (!done && mp[pick] < src_len[pick]) begin
                    exp_q.push_back(src_data[pick][mp[pick]]);
                    done = src_last[pick][mp[pick]];
                    mp[pick]++;
                end
            end
            last = pick;
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            if (src_ptr[i] < src_len[i] && !abandoned[i]) begin
                req_data[8*i +: 8] = src_data[i][src_ptr[i]];
                req_last[i] = src_last[i][src_ptr[i]];
                if (gaps_en && inpkt[i] && lowrun[i] < 3 && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b0; lowrun[i]++;
                end else begin
                    req_valid[i] = 1'b1; lowrun[i] = 0;
                end
            end else begin
                req_valid[i] = 1'b0; req_last[i] = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
            end
        end
    endtask

    // Runs the scripted sources cycle by cycle and records what the DUT does.
    task automatic run_traffic(input int max_cyc);
        int         cyc, idle, left;
        bit         started, alldone;
        logic       ps, pf, pb;
        logic [7:0] pd;
        bit         fire[NR];
        obs_q.delete(); gnt_q.delete();
        b2b_viol = 0; full_viol = 0; ready_viol = 0; hold_viol = 0;
        abort_cnt = 0; abort_busy_viol = 0; fire_cyc = -1; abort_cyc = -1;
        budget_hit = 1'b0;
        cyc = 0; idle = 0; left = 0; started = 1'b0;
        ps = 1'b0; pf = 1'b0; pb = 1'b0; pd = tx_data;
        tx_full = 1'b0;
        drive_inputs();
        while (1) begin
            @(negedge clk);
            cyc++;
            if (tx_strobe) begin
                if (ps) b2b_viol++;
                if (pf) full_viol++;
                obs_q.push_back(tx_data);
            end else if (tx_data !== pd) begin
                hold_viol++;
            end
            if (busy && !pb) gnt_q.push_back(int'(grant_id));
            if (abort) begin
                abort_cnt++; abort_cyc = cyc;
                if (busy) abort_busy_viol++;
            end
            if (|req_ready && (tx_full || tx_strobe)) ready_viol++;
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i] && (!busy || int'(grant_id) != i)) ready_viol++;
                fire[i] = req_valid[i] && req_ready[i];
            end
            ps = tx_strobe; pf = tx_full; pd = tx_data; pb = busy;
            alldone = 1'b1;
            for (int i = 0; i < NR; i++)
                if (src_ptr[i] < src_len[i] && !abandoned[i]) alldone = 1'b0;
            if (alldone && !busy && !tx_strobe) idle++; else idle = 0;
            if (idle >= 3) break;
            if (cyc >= max_cyc) begin budget_hit = 1'b1; break; end
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (fire[i]) begin
                    inpkt[i] = !src_last[i][src_ptr[i]];
                    src_ptr[i]++;
                    if (src_drop[i]) begin abandoned[i] = 1'b1; fire_cyc = cyc; end
                end
            end
            if (full_mode == 1) begin
                tx_full = ($urandom_range(0, 3) == 0);
            end else if (full_mode == 2) begin
                if (!started && obs_q.size() >= full_after) begin started = 1'b1; left = 50; end
                tx_full = (left > 0);
                if (left > 0) left--;
            end else begin
                tx_full = 1'b0;
            end
            drive_inputs();
        end
        req_valid = '0; req_last = '0; tx_full = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; req_last = 4'hF; req_data = 32'h0403_0201; tx_full = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx_strobe !== 1'b0) begin n_mis++; $display("FAIL reset_strobe: got %b want 0", tx_strobe); end
        n_cmp++; if (tx_data !== 8'h00) begin n_mis++; $display("FAIL reset_data: got %h want 00", tx_data); end
        n_cmp++; if (abort !== 1'b0) begin n_mis++; $display("FAIL reset_abort: got %b want 0", abort); end
        n_cmp++; if (grant_id !== 2'd0) begin n_mis++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (req_ready !== 4'h0) begin n_mis++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    endtask

    task automatic test_single();
        logic [7:0] want[3];
        want[0] = 8'h31; want[1] = 8'h41; want[2] = 8'h42;
        do_reset(); clear_sources();
        add_byte(1, 8'h41, 1'b0); add_byte(1, 8'h42, 1'b1);
        run_traffic(200);
        n_cmp++; if (budget_hit) begin n_mis++; $display("FAIL single_budget: got expired want idle"); end
        n_cmp++; if (obs_q.size() != 3) begin n_mis++; $display("FAIL single_count: got %0d want 3", obs_q.size()); end
        for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
            n_cmp++; if (obs_q[k] !== want[k]) begin n_mis++; $display("FAIL single_byte%0d: got %h want %h", k, obs_q[k], want[k]); end
        end
        n_cmp++; if (b2b_viol != 0) begin n_mis++; $display("FAIL single_gap: got %0d back-to-back want 0", b2b_viol); end
        n_cmp++; if (gnt_q.size() != 1 || gnt_q[0] != 1) begin n_mis++; $display("FAIL single_grant: got %0d grants want one of id 1", gnt_q.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_two_requesters();
        do_reset(); clear_sources();
        add_byte(0, 8'hC0, 1'b0); add_byte(0, 8'hC1, 1'b0); add_byte(0, 8'hC2, 1'b1);
        add_byte(2, 8'hD0, 1'b0); add_byte(2, 8'hD1, 1'b1);
        build_expected();
        run_traffic(300);
        n_cmp++; if (budget_hit) begin n_mis++; $display("FAIL two_budget: got expired want idle"); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_mis++; $display("FAIL two_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_cmp++; if (obs_q[k] !== exp_q[k]) begin n_mis++; $display("FAIL two_byte%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
        end
        n_cmp++; if (gnt_q.size() != 2 || gnt_q[0] != 0 || gnt_q[1] != 2) begin n_mis++; $display("FAIL two_order: got %0d grants want 0 then 2", gnt_q.size()); end
        n_cmp++; if (b2b_viol != 0 || hold_viol != 0) begin n_mis++; $display("FAIL two_proto: got b2b %0d hold %0d want 0 0", b2b_viol, hold_viol); end
    endtask

    task automatic test_round_robin();
        int want[8];
        do_reset(); clear_sources();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < NR; i++) add_byte(i, 8'(8'h10 * i + p), 1'b1);
        for (int k = 0; k < 8; k++) want[k] = k % 4;
        run_traffic(400);
        n_cmp++; if (budget_hit) begin n_mis++; $display("FAIL rr_budget: got expired want idle"); end
        n_cmp++; if (gnt_q.size() != 8) begin n_mis++; $display("FAIL rr_count: got %0d want 8", gnt_q.size()); end
        for (int k = 0; k < 8 && k < gnt_q.size(); k++) begin
            n_cmp++; if (gnt_q[k] != want[k]) begin n_mis++; $display("FAIL rr_grant%0d: got %0d want %0d", k, gnt_q[k], want[k]); end
        end
    endtask

    task automatic test_full_stall();
        do_reset(); clear_sources();
        for (int b = 0; b < 5; b++) add_byte(3, 8'(8'hA0 + b), b == 4);
        full_mode = 2; full_after = 2;
        build_expected();
        run_traffic(400);
        n_cmp++; if (budget_hit) begin n_mis++; $display("FAIL full_budget: got expired want idle"); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_mis++; $display("FAIL full_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_cmp++; if (obs_q[k] !== exp_q[k]) begin n_mis++; $display("FAIL full_byte%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
        end
        n_cmp++; if (full_viol != 0) begin n_mis++; $display("FAIL full_strobe: got %0d strobes after full want 0", full_viol); end
        n_cmp++; if (ready_viol != 0) begin n_mis++; $display("FAIL full_ready: got %0d bad ready cycles want 0", ready_viol); end
        n_cmp++; if (abort_cnt != 0) begin n_mis++; $display("FAIL full_abort: got %0d aborts want 0", abort_cnt); end
    endtask

    task automatic test_timeout();
        do_reset(); clear_sources();
        add_byte(0, 8'hE0, 1'b0); add_byte(0, 8'hE1, 1'b1); src_drop[0] = 1'b1;
        add_byte(1, 8'hF0, 1'b0); add_byte(1, 8'hF1, 1'b1);
        build_expected();
        run_traffic(300);
        n_cmp++; if (budget_hit) begin n_mis++; $display("FAIL tmo_budget: got expired want idle"); end
        n_cmp++; if (abort_cnt != 1) begin n_mis++; $display("FAIL tmo_abort_count: got %0d want 1", abort_cnt); end
        n_cmp++; if (abort_cyc - fire_cyc != TMO + 1) begin n_mis++; $display("FAIL tmo_latency: got %0d want %0d", abort_cyc - fire_cyc, TMO + 1); end
        n_cmp++; if (abort_busy_viol != 0) begin n_mis++; $display("FAIL tmo_busy: got %0d busy-with-abort want 0", abort_busy_viol); end
        n_cmp++; if (gnt_q.size() != 2 || gnt_q[0] != 0 || gnt_q[1] != 1) begin n_mis++; $display("FAIL tmo_order: got %0d grants want 0 then 1", gnt_q.size()); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_mis++; $display("FAIL tmo_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_cmp++; if (obs_q[k] !== exp_q[k]) begin n_mis++; $display("FAIL tmo_byte%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_reset_mid_packet();
        int         seen, late;
        bit         acc;
        logic [7:0] got[$];
        do_reset(); clear_sources();
        req_valid = 4'b0100; req_data[23:16] = 8'h55; req_last = 4'b0000;
        seen = 0;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            @(negedge clk);
            if (tx_strobe) seen++;
        end
        n_cmp++; if (seen != 2) begin n_mis++; $display("FAIL rstmid_pre: got %0d strobes want 2", seen); end
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL rstmid_busy_pre: got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (tx_strobe !== 1'b0) begin n_mis++; $display("FAIL rstmid_strobe: got %b want 0", tx_strobe); end
        n_cmp++; if (tx_data !== 8'h00) begin n_mis++; $display("FAIL rstmid_data: got %h want 00", tx_data); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (grant_id !== 2'd0) begin n_mis++; $display("FAIL rstmid_grant: got %0d want 0", grant_id); end
        n_cmp++; if (req_ready !== 4'h0) begin n_mis++; $display("FAIL rstmid_ready: got %b want 0000", req_ready); end
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        late = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (tx_strobe) late++;
        end
        n_cmp++; if (late != 0) begin n_mis++; $display("FAIL rstmid_stale: got %0d strobes want 0", late); end
        req_valid[2] = 1'b1; req_data[23:16] = 8'h66; req_last[2] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (tx_strobe) got.push_back(tx_data);
            acc = req_valid[2] && req_ready[2];
            @(posedge clk);
            #1;
            if (acc) req_valid[2] = 1'b0;
        end
        n_cmp++; if (got.size() != 2) begin n_mis++; $display("FAIL rstmid_resume_count: got %0d want 2", got.size()); end
        if (got.size() == 2) begin
            n_cmp++; if (got[0] !== 8'h32) begin n_mis++; $display("FAIL rstmid_resume_hdr: got %h want 32", got[0]); end
            n_cmp++; if (got[1] !== 8'h66) begin n_mis++; $display("FAIL rstmid_resume_byte: got %h want 66", got[1]); end
        end
        req_valid = '0; req_last = '0;
    endtask

    task automatic test_random();
        int np, len;
        for (int r = 0; r < 3; r++) begin
            do_reset(); clear_sources();
            gaps_en = 1'b1; full_mode = 1;
            for (int i = 0; i < NR; i++) begin
                np = (i == r) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
                for (int p = 0; p < np; p++) begin
                    len = int'($urandom_range(1, 4));
                    for (int b = 0; b < len; b++) add_byte(i, 8'($urandom), b == len - 1);
                end
            end
            build_expected();
            run_traffic(3000);
            n_cmp++; if (budget_hit) begin n_mis++; $display("FAIL rnd%0d_budget: got expired want idle", r); end
            n_cmp++; if (obs_q.size() != exp_q.size()) begin n_mis++; $display("FAIL rnd%0d_count: got %0d want %0d", r, obs_q.size(), exp_q.size()); end
            for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
                n_cmp++; if (obs_q[k] !== exp_q[k]) begin n_mis++; $display("FAIL rnd%0d_byte%0d: got %h want %h", r, k, obs_q[k], exp_q[k]); end
            end
            n_cmp++; if (gnt_q != exp_g) begin n_mis++; $display("FAIL rnd%0d_order: got %0d grants want %0d", r, gnt_q.size(), exp_g.size()); end
            n_cmp++; if (b2b_viol != 0 || full_viol != 0) begin n_mis++; $display("FAIL rnd%0d_strobe: got b2b %0d full %0d want 0 0", r, b2b_viol, full_viol); end
            n_cmp++; if (ready_viol != 0 || hold_viol != 0) begin n_mis++; $display("FAIL rnd%0d_ready_hold: got %0d %0d want 0 0", r, ready_viol, hold_viol); end
            n_cmp++; if (abort_cnt != 0) begin n_mis++; $display("FAIL rnd%0d_abort: got %0d want 0", r, abort_cnt); end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; tx_full = 1'b0;
        test_reset();
        test_single();
        test_two_requesters();
        test_round_robin();
        test_full_stall();
        test_timeout();
        test_reset_mid_packet();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte-stream requesters (2..8).
REQ-002 Parameter HEADER_EN, default 1, prefix each packet with a source-ID byte.
REQ-003 Parameter TIMEOUT, default 1023, idle-cycle limit mid-packet before abort.
REQ-004 clk  input  1  system clock (16 MHz); one clock; all logic on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-007 req_data  input  8*NUM_REQ  per-requester byte; requester i at bits [8i+7:8i].
REQ-008 req_last  input  NUM_REQ  marks final byte of the requester's packet.
REQ-009 req_ready  output  NUM_REQ  per-requester byte accept.
REQ-010 tx_data  output  8  byte to UART transmitter FIFO.
REQ-011 tx_strobe  output  1  one-cycle write pulse to UART transmitter FIFO.
REQ-012 tx_full  input  1  UART transmitter FIFO full.
REQ-013 busy  output  1  high while a packet is granted (state not IDLE).
REQ-014 grant_id  output  CLOG2(NUM_REQ)  index of current/last granted requester.
REQ-015 abort  output  1  one-cycle pulse when a packet is abandoned on timeout.

Function
REQ-016 States IDLE, HEADER, PAYLOAD; busy = (state != IDLE).
REQ-017 IDLE: any req_valid high -> register winner in grant_id, go HEADER if HEADER_EN else PAYLOAD; no byte moves in the arbitration cycle.
REQ-018 Winner is round-robin: first valid index searching upward (wrapping) from last_grant+1.
REQ-019 Grant is held for the whole packet; no other requester gets req_ready until release.
REQ-020 Issue condition: issue_ok = !tx_full && !tx_strobe (at most one strobe every two cycles so tx_full reflects the previous write).
REQ-021 HEADER: when issue_ok, next cycle tx_strobe=1, tx_data=8'h30+grant_id; go PAYLOAD.
REQ-022 PAYLOAD: req_ready[grant_id] = issue_ok combinationally; all other req_ready bits 0.
REQ-023 Transfer = req_valid[g] && req_ready[g]; next cycle tx_strobe=1, tx_data=req_data[g] (one-cycle latency, registered outputs).
REQ-024 Transfer with req_last[g] high -> last_grant<=g, go IDLE; new arbitration allowed the following cycle.
REQ-025 Stall counter clears on every transfer and on entry to PAYLOAD, increments each PAYLOAD cycle with req_valid[g] low.
REQ-026 Stall counter reaching TIMEOUT -> abort pulse, last_grant<=g, go IDLE; no further strobe for that packet.
REQ-027 tx_full held high stalls indefinitely without timeout (counter counts only valid-low cycles).
REQ-028 tx_strobe is never high for two consecutive cycles; tx_data is held stable when tx_strobe is low.
REQ-029 req_valid dropping in the cycle of grant is tolerated: PAYLOAD waits or times out.

Reset
REQ-030 rst high forces state=IDLE, tx_strobe=0, tx_data=8'h00, abort=0, grant_id=0, stall counter=0, last_grant=NUM_REQ-1 (requester 0 wins first).
REQ-031 Reset mid-packet discards the packet; no strobe is issued until after reset deasserts and a new arbitration occurs.

Structure
REQ-032 Shared package holds state encoding, HEADER_BASE=8'h30, and the CLOG2 width helper.
REQ-033 One sub-module rr_arbiter: combinational round-robin picker taking valid vector and last_grant, returning winner index and any_valid.

Verification
REQ-034 Single requester 1 sends 8'h41,8'h42(last), tx_full=0 -> strobes carry 8'h31,8'h41,8'h42, gaps >=1 cycle, busy drops after last.
REQ-035 Requesters 0 and 2 both valid from reset -> packet from 0 fully precedes packet from 2; grant_id 0 then 2; no interleaving.
REQ-036 All four continuously valid with 1-byte packets -> grant order 0,1,2,3,0.
REQ-037 tx_full held high 50 cycles mid-packet -> no strobe, req_ready low, no abort; bytes resume in order after release.
REQ-038 Granted requester drops valid after first byte, TIMEOUT=15 -> abort pulse on cycle 15 of stall, busy low, next requester granted.
REQ-039 rst asserted between payload bytes -> outputs at reset values immediately (async), no stale byte strobed afterward.
